// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side sram-like to AXI4 read bridge (single-beat, in-order).
// Optional macro: IBRIDGE_RRESP_CHECK_EN enables the sticky bus_err flag.
module inst_axi_rd_bridge #(
    parameter logic [3:0] INST_ARID       = 4'd0,
    parameter int         MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    ar_state_e       r_state;
    logic            r_arvalid;
    logic [31:0]     r_araddr;
    logic [2:0]      r_arsize;
    logic [CW-1:0]   r_outstanding;
    logic            r_data_ok;
    logic [31:0]     r_rdata;

    logic            w_accept;
    logic            w_rhs;
    logic            w_rready;
    logic            w_unused;

    assign w_accept = inst_sram_req & ~inst_sram_wr
                    & (r_state == AR_IDLE)
                    & (r_outstanding < MAX_CNT);
    assign w_rready = (r_outstanding != '0);
    assign w_rhs    = rvalid & w_rready;

    // rlast is redundant with arlen=0; rid/rresp only matter with checking on
    assign w_unused = &{1'b0, rlast, rid, rresp};

    assign inst_sram_addr_ok = w_accept;
    assign inst_sram_data_ok = r_data_ok;
    assign inst_sram_rdata   = r_rdata;
    assign arid    = INST_ARID;
    assign araddr  = r_araddr;
    assign arlen   = 8'd0;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = r_arvalid;
    assign rready  = w_rready;

    // AR channel FSM: hold address stable until arready, one request at a time
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= AR_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= 32'd0;
            r_arsize  <= 3'd0;
        end else begin
            unique case (r_state)
                AR_IDLE: begin
                    if (w_accept) begin
                        r_state   <= AR_SEND;
                        r_arvalid <= 1'b1;
                        r_araddr  <= inst_sram_addr;
                        r_arsize  <= {1'b0, inst_sram_size};
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        r_state   <= AR_IDLE;
                        r_arvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= AR_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Reads accepted but not yet returned; accept is gated so it cannot wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outstanding <= '0;
        end else begin
            unique case ({w_accept, w_rhs})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Register the R beat toward fetch: one-cycle data_ok, rdata held between beats
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_ok <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_data_ok <= w_rhs;
            if (w_rhs) begin
                r_rdata <= rdata;
            end
        end
    end

`ifdef IBRIDGE_RRESP_CHECK_EN
    logic r_bus_err;

    // Sticky error on bad response code or foreign ID
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus_err <= 1'b0;
        end else if (w_rhs && ((rresp != 2'b00) || (rid != INST_ARID))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge.
// Default parameters: INST_ARID=0, MAX_OUTSTANDING=2.
module tb_inst_axi_rd_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int hs0;
    logic [31:0] berr_exp;

    inst_axi_rd_bridge dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready),
        .bus_err           (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn && arvalid && arready) begin
            hs_cnt = hs_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef IBRIDGE_RRESP_CHECK_EN
        berr_exp = 32'd1;
`else
        berr_exp = 32'd0;
`endif
        resetn = 1'b0;
        inst_sram_req = 1'b0;
        inst_sram_wr = 1'b0;
        inst_sram_size = 2'b10;
        inst_sram_addr = 32'd0;
        arready = 1'b0;
        rid = 4'd0;
        rdata = 32'd0;
        rresp = 2'b00;
        rlast = 1'b1;
        rvalid = 1'b0;
        repeat (2) tick();

        // reset state
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("rst_rdata", inst_sram_rdata, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("arlen", {24'd0, arlen}, 32'd0);
        chk("arburst", {30'd0, arburst}, 32'd1);
        chk("arid", {28'd0, arid}, 32'd0);

        // single read, minimum latency
        arready = 1'b1;
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1c000000;
        #1;
        chk("t1_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0;
        chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
        chk("t1_araddr", araddr, 32'h1c000000);
        chk("t1_arsize", {29'd0, arsize}, 32'd2);
        tick();
        chk("t1_arvalid_lo", {31'd0, arvalid}, 32'd0);
        rvalid = 1'b1;
        rdata = 32'h02c00000;
        #1;
        chk("t1_rready", {31'd0, rready}, 32'd1);
        tick();
        rvalid = 1'b0;
        chk("t1_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        chk("t1_rdata", inst_sram_rdata, 32'h02c00000);
        tick();
        chk("t1_data_ok_lo", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("t1_rdata_hold", inst_sram_rdata, 32'h02c00000);
        chk("t1_rready_lo", {31'd0, rready}, 32'd0);

        // arready held low for 5 cycles
        arready = 1'b0;
        hs0 = hs_cnt;
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1c000040;
        #1;
        chk("t2_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_addr = 32'h1c000080;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_addr_ok_lo", {31'd0, inst_sram_addr_ok}, 32'd0);
            chk("t2_arvalid", {31'd0, arvalid}, 32'd1);
            chk("t2_araddr", araddr, 32'h1c000040);
            tick();
        end
        inst_sram_req = 1'b0;
        arready = 1'b1;
        tick();
        chk("t2_hs_count", hs_cnt - hs0, 32'd1);
        chk("t2_arvalid_lo", {31'd0, arvalid}, 32'd0);
        rvalid = 1'b1;
        rdata = 32'h11111111;
        tick();
        rvalid = 1'b0;
        chk("t2_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        chk("t2_rdata", inst_sram_rdata, 32'h11111111);

        // outstanding limit with R stalled, then ordered returns
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h00000100;
        #1;
        chk("t3_acc_a", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_addr = 32'h00000104;
        #1;
        chk("t3_busy_send", {31'd0, inst_sram_addr_ok}, 32'd0);
        tick();
        #1;
        chk("t3_acc_b", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        chk("t3_araddr_b", araddr, 32'h00000104);
        inst_sram_addr = 32'h00000108;
        tick();
        #1;
        chk("t3_full", {31'd0, inst_sram_addr_ok}, 32'd0);
        chk("t3_rready", {31'd0, rready}, 32'd1);
        tick();
        #1;
        chk("t3_full2", {31'd0, inst_sram_addr_ok}, 32'd0);
        rvalid = 1'b1;
        rdata = 32'haaaa0001;
        #1;
        chk("t3_full_rbeat", {31'd0, inst_sram_addr_ok}, 32'd0);
        tick();
        chk("t3_data_a", inst_sram_rdata, 32'haaaa0001);
        chk("t3_dok_a", {31'd0, inst_sram_data_ok}, 32'd1);
        rdata = 32'hbbbb0002;
        #1;
        chk("t3_acc_c", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0;
        rvalid = 1'b0;
        chk("t3_data_b", inst_sram_rdata, 32'hbbbb0002);
        chk("t3_dok_b", {31'd0, inst_sram_data_ok}, 32'd1);
        chk("t3_rready_c", {31'd0, rready}, 32'd1);
        chk("t3_arvalid_c", {31'd0, arvalid}, 32'd1);
        chk("t3_araddr_c", araddr, 32'h00000108);
        tick();
        rvalid = 1'b1;
        rdata = 32'hcccc0003;
        tick();
        rvalid = 1'b0;
        chk("t3_data_c", inst_sram_rdata, 32'hcccc0003);
        chk("t3_rready_empty", {31'd0, rready}, 32'd0);

        // async reset with a read outstanding
        arready = 1'b0;
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h00000200;
        #1;
        chk("t4_acc", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0;
        chk("t4_arvalid", {31'd0, arvalid}, 32'd1);
        chk("t4_rready", {31'd0, rready}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t4_arvalid_rst", {31'd0, arvalid}, 32'd0);
        chk("t4_rready_rst", {31'd0, rready}, 32'd0);
        chk("t4_data_ok_rst", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("t4_araddr_rst", araddr, 32'd0);
        #1;
        resetn = 1'b1;
        rvalid = 1'b1;
        rdata = 32'hdeadbeef;
        #1;
        chk("t4_stray_rready", {31'd0, rready}, 32'd0);
        tick();
        chk("t4_stray_dok", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("t4_stray_rdata", inst_sram_rdata, 32'd0);
        rvalid = 1'b0;
        tick();

        // write requests are never accepted
        arready = 1'b1;
        hs0 = hs_cnt;
        inst_sram_req = 1'b1;
        inst_sram_wr = 1'b1;
        inst_sram_addr = 32'h00000400;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t5_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
            chk("t5_arvalid", {31'd0, arvalid}, 32'd0);
            tick();
        end
        inst_sram_req = 1'b0;
        inst_sram_wr = 1'b0;
        chk("t5_hs_count", hs_cnt - hs0, 32'd0);

        // error response
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h00000300;
        tick();
        inst_sram_req = 1'b0;
        tick();
        rvalid = 1'b1;
        rresp = 2'b10;
        rdata = 32'habcd0123;
        tick();
        rvalid = 1'b0;
        rresp = 2'b00;
        chk("t6_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
        chk("t6_rdata", inst_sram_rdata, 32'habcd0123);
        chk("t6_bus_err", {31'd0, bus_err}, berr_exp);
        repeat (3) tick();
        chk("t6_bus_err_sticky", {31'd0, bus_err}, berr_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
